// File: rtl/jk_pkg.sv
// Shared definitions for the JK mode register family: operation modes and per-bit JK codes.
package jk_pkg;

   localparam logic [1:0] MODE_JK   = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // {j,k} codes for a single JK bit
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_bit_next.sv
// Combinational next-state of a single JK bit from its current value and its J/K inputs.
module jk_bit_next
   import jk_pkg::*;
(
   input  logic q,
   input  logic j,
   input  logic k,
   output logic q_next
);

   always_comb begin
      q_next = q;
      case ({j, k})
         JK_HOLD: q_next = q;
         JK_RST:  q_next = 1'b0;
         JK_SET:  q_next = 1'b1;
         JK_TGL:  q_next = ~q;
         default: q_next = q;
      endcase
   end

endmodule

// File: rtl/jk_mode_register.sv
// Multi-bit register with per-bit JK, up-count, down-count and parallel-load modes,
// plus a combinational terminal-count flag and a registered change pulse.
module jk_mode_register
   import jk_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc,
   output logic             changed
);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] qb_reg;
   logic             changed_reg;
   logic [WIDTH-1:0] jk_next;
   logic [WIDTH-1:0] q_next;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk_bit
         jk_bit_next u_bit (
            .q      (q_reg[gi]),
            .j      (j[gi]),
            .k      (k[gi]),
            .q_next (jk_next[gi])
         );
      end
   endgenerate

   // All four codes are enumerated, so the default arm only fires in simulation
   // when mode carries X/Z; it poisons q so the bad select is visible.
   always_comb begin
      q_next = q_reg;
      if (en) begin
         case (mode)
            MODE_JK:   q_next = jk_next;
            MODE_UP:   q_next = q_reg + 1'b1;
            MODE_DOWN: q_next = q_reg - 1'b1;
            MODE_LOAD: q_next = d;
            default:   q_next = {WIDTH{1'bx}};
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         q_reg       <= RESET_VAL;
         qb_reg      <= ~RESET_VAL;
         changed_reg <= 1'b0;
      end else begin
         q_reg       <= q_next;
         qb_reg      <= ~q_next;
         changed_reg <= (q_next != q_reg);
      end
   end

   assign tc = en & (((mode == MODE_UP)   & (&q_reg)) |
                     ((mode == MODE_DOWN) & ~(|q_reg)));

   assign q       = q_reg;
   assign qb      = qb_reg;
   assign changed = changed_reg;

endmodule
